// File: rtl/fm_tile_loader.sv
// Tile loader: collects CH*ROWS row beats into one flat binary tile for the conv engine.
// Latency: tile_valid rises the cycle after the final beat is accepted; one bubble cycle on handoff.
// Backpressure: single buffer, so s_ready stays low from tile completion until tile_ready is taken.
module fm_tile_loader #(
   parameter int CH     = 3,
   parameter int ROWS   = 12,
   parameter int COLS   = 12,
   parameter int BEAT_W = 12,
   parameter int TILE_W = CH * ROWS * COLS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BEAT_W-1:0] s_data,
   input  logic              s_valid,
   input  logic              s_last,
   output logic              s_ready,
   output logic [TILE_W-1:0] tile_data,
   output logic              tile_valid,
   input  logic              tile_ready,
   output logic              frame_err,
   output logic [5:0]        beat_cnt
);

   localparam int         NBEATS   = CH * ROWS;
   localparam logic [5:0] LAST_IDX = 6'(NBEATS - 1);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [5:0]        beat_cnt_q, beat_cnt_d;
   logic [TILE_W-1:0] tile_data_q, tile_data_d;
   logic              tile_valid_q, tile_valid_d;
   logic              frame_err_q, frame_err_d;
   logic              beat_acc;
   logic              is_final;

   // Ready only while filling; forced low during reset so no beat is taken on a reset edge.
   assign s_ready  = (state_q == FILL) && !rst;
   assign beat_acc = s_valid && s_ready;
   assign is_final = (beat_cnt_q == LAST_IDX);

   assign tile_data  = tile_data_q;
   assign tile_valid = tile_valid_q;
   assign frame_err  = frame_err_q;
   assign beat_cnt   = beat_cnt_q;

   // Next-state: write accepted beat at its row slot, track framing, hand off the full tile.
   always_comb begin
      state_d      = state_q;
      beat_cnt_d   = beat_cnt_q;
      tile_data_d  = tile_data_q;
      tile_valid_d = tile_valid_q;
      frame_err_d  = 1'b0;
      case (state_q)
         FILL: begin
            if (beat_acc) begin
               tile_data_d[beat_cnt_q * BEAT_W +: BEAT_W] = s_data;
               if (is_final) begin
                  // Tile is issued even when s_last was missing; the error is just flagged.
                  state_d      = HOLD;
                  tile_valid_d = 1'b1;
                  beat_cnt_d   = '0;
                  frame_err_d  = !s_last;
               end else if (s_last) begin
                  // Early last: drop the partial tile and restart at beat 0.
                  beat_cnt_d  = '0;
                  frame_err_d = 1'b1;
               end else begin
                  beat_cnt_d = beat_cnt_q + 6'd1;
               end
            end
         end
         HOLD: begin
            if (tile_ready) begin
               state_d      = FILL;
               tile_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   // State and registered outputs, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FILL;
         beat_cnt_q   <= '0;
         tile_data_q  <= '0;
         tile_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_cnt_q   <= beat_cnt_d;
         tile_data_q  <= tile_data_d;
         tile_valid_q <= tile_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

endmodule

// File: tb/tb_fm_tile_loader.sv
// Bench for fm_tile_loader: table vectors, directed framing/reset sequences, random run.
// Every cycle is also checked against a queue-based model of tile assembly.
// Outputs sampled 1 time unit after the rising edge.
module tb_fm_tile_loader;

   localparam int NB = 36;
   localparam int BW = 12;
   localparam int TW = 432;

   logic          clk = 1'b0;
   logic          rst;
   logic [BW-1:0] s_data;
   logic          s_valid;
   logic          s_last;
   logic          s_ready;
   logic [TW-1:0] tile_data;
   logic          tile_valid;
   logic          tile_ready;
   logic          frame_err;
   logic [5:0]    beat_cnt;

   always #5 clk = ~clk;

   fm_tile_loader dut (
      .clk        (clk),
      .rst        (rst),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_last     (s_last),
      .s_ready    (s_ready),
      .tile_data  (tile_data),
      .tile_valid (tile_valid),
      .tile_ready (tile_ready),
      .frame_err  (frame_err),
      .beat_cnt   (beat_cnt)
   );

   int nvec = 0;
   int nerr = 0;

   // Model: beats gathered so far for the current tile, the visible tile image, hold flag, error pulse.
   logic [BW-1:0] m_q[$];
   logic [TW-1:0] m_tile = '0;
   bit            m_hold = 1'b0;
   bit            m_err  = 1'b0;

   typedef struct {
      bit            r;
      bit            v;
      logic [BW-1:0] d;
      bit            l;
      bit            tr;
      bit            e_rdy;
      bit            e_tv;
      bit            e_err;
      int            e_cnt;
      bit            chk_tile;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [TW-1:0] mk_tile(logic [BW-1:0] key);
      logic [TW-1:0] t = '0;
      for (int k = 0; k < NB; k++) t[k*BW +: BW] = 12'(k) ^ key;
      return t;
   endfunction

   function automatic vec_t mkv(bit r, bit v, logic [BW-1:0] d, bit l, bit tr,
                                bit e_rdy, bit e_tv, bit e_err, int e_cnt, bit chk_tile);
      vec_t x;
      x.r = r; x.v = v; x.d = d; x.l = l; x.tr = tr;
      x.e_rdy = e_rdy; x.e_tv = e_tv; x.e_err = e_err; x.e_cnt = e_cnt; x.chk_tile = chk_tile;
      return x;
   endfunction

   task automatic chk(string name, logic [TW-1:0] got, logic [TW-1:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic model_edge(bit r, bit v, logic [BW-1:0] d, bit l, bit tr);
      int k;
      if (r) begin
         m_q.delete();
         m_hold = 1'b0;
         m_err  = 1'b0;
         m_tile = '0;
      end else if (!m_hold) begin
         m_err = 1'b0;
         if (v) begin
            k = m_q.size();
            m_tile[k*BW +: BW] = d;
            m_q.push_back(d);
            if (m_q.size() == NB) begin
               m_hold = 1'b1;
               m_err  = !l;
               m_q.delete();
            end else if (l) begin
               m_err = 1'b1;
               m_q.delete();
            end
         end
      end else begin
         m_err = 1'b0;
         if (tr) m_hold = 1'b0;
      end
   endtask

   // Apply one cycle of inputs, clock, then compare every output with the model.
   task automatic step(bit r, bit v, logic [BW-1:0] d, bit l, bit tr);
      rst = r; s_valid = v; s_data = d; s_last = l; tile_ready = tr;
      @(posedge clk);
      #1;
      model_edge(r, v, d, l, tr);
      chk("mdl_s_ready",    TW'(s_ready),    TW'(!m_hold && !r));
      chk("mdl_tile_valid", TW'(tile_valid), TW'(m_hold));
      chk("mdl_frame_err",  TW'(frame_err),  TW'(m_err));
      chk("mdl_beat_cnt",   TW'(beat_cnt),   TW'(m_q.size()));
      chk("mdl_tile_data",  tile_data,       m_tile);
   endtask

   task automatic feed(logic [BW-1:0] key, int n, int last_at, bit tr);
      for (int k = 0; k < n; k++) step(1'b0, 1'b1, 12'(k) ^ key, (k == last_at), tr);
   endtask

   logic [TW-1:0] gold;
   int            acc_k;
   bit            v_r;
   bit            acc;

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; tile_ready = 1'b0;
      gold = mk_tile(12'hA5A);

      // Table: reset, clean tile with tile_ready high, then tile held under backpressure.
      for (int i = 0; i < 2; i++) vecs.push_back(mkv(1, 0, 12'h0, 0, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < NB; k++)
         vecs.push_back(mkv(0, 1, 12'(k) ^ 12'hA5A, k == NB-1, 1,
                            k != NB-1, k == NB-1, 0, (k == NB-1) ? 0 : k+1, k == NB-1));
      vecs.push_back(mkv(0, 0, 12'h0, 0, 1, 1, 0, 0, 0, 0));
      for (int k = 0; k < NB; k++)
         vecs.push_back(mkv(0, 1, 12'(k) ^ 12'hA5A, k == NB-1, 0,
                            k != NB-1, k == NB-1, 0, (k == NB-1) ? 0 : k+1, k == NB-1));
      for (int i = 0; i < 10; i++) vecs.push_back(mkv(0, 1, 12'hFFF, 0, 0, 0, 1, 0, 0, 1));
      vecs.push_back(mkv(0, 1, 12'hFFF, 0, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 0, 12'h0, 0, 0, 1, 0, 0, 0, 0));

      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].tr);
         chk("tbl_s_ready",    TW'(s_ready),    TW'(vecs[i].e_rdy));
         chk("tbl_tile_valid", TW'(tile_valid), TW'(vecs[i].e_tv));
         chk("tbl_frame_err",  TW'(frame_err),  TW'(vecs[i].e_err));
         chk("tbl_beat_cnt",   TW'(beat_cnt),   TW'(vecs[i].e_cnt));
         if (vecs[i].chk_tile) chk("tbl_tile_data", tile_data, gold);
      end

      // Early last on beat 5: one error pulse, no tile, then a clean tile.
      feed(12'h0F0, 6, 5, 1'b0);
      chk("t3_err_pulse", TW'(frame_err), TW'(1));
      chk("t3_no_tile",   TW'(tile_valid), TW'(0));
      chk("t3_cnt_zero",  TW'(beat_cnt), TW'(0));
      step(0, 0, 12'h0, 0, 0);
      chk("t3_err_clear", TW'(frame_err), TW'(0));
      feed(12'hA5A, NB, NB-1, 1'b0);
      chk("t3_tile_valid", TW'(tile_valid), TW'(1));
      chk("t3_tile_data",  tile_data, gold);
      chk("t3_beat0",      TW'(tile_data[11:0]), TW'(12'hA5A));
      step(0, 0, 12'h0, 0, 1);

      // Missing last: tile still issued, error flagged in the same cycle.
      feed(12'h777, NB, -1, 1'b0);
      chk("t4_tile_valid", TW'(tile_valid), TW'(1));
      chk("t4_err",        TW'(frame_err), TW'(1));
      chk("t4_tile_data",  tile_data, mk_tile(12'h777));
      step(0, 0, 12'h0, 0, 1);
      chk("t4_err_clear",  TW'(frame_err), TW'(0));

      // Reset part way through a tile: restart from beat 0.
      feed(12'h111, 20, -1, 1'b0);
      chk("t5_cnt20", TW'(beat_cnt), TW'(20));
      step(1, 1, 12'h123, 0, 0);
      chk("t5_rst_cnt",   TW'(beat_cnt), TW'(0));
      chk("t5_rst_tile",  tile_data, TW'(0));
      chk("t5_rst_ready", TW'(s_ready), TW'(0));
      feed(12'h3C3, NB-1, -1, 1'b0);
      chk("t5_no_early_tile", TW'(tile_valid), TW'(0));
      step(0, 1, 12'(NB-1) ^ 12'h3C3, 1, 0);
      chk("t5_tile_valid", TW'(tile_valid), TW'(1));
      chk("t5_beat0",      TW'(tile_data[11:0]), TW'(12'h3C3));
      chk("t5_tile_data",  tile_data, mk_tile(12'h3C3));
      step(0, 0, 12'h0, 0, 1);

      // Random valid bubbles across one full tile.
      acc_k = 0;
      for (int c = 0; c < 500 && acc_k < NB; c++) begin
         v_r = 1'($urandom % 2);
         acc = v_r && !m_hold;
         step(0, v_r, 12'(acc_k) ^ 12'hA5A, acc_k == NB-1, 0);
         if (acc) acc_k++;
      end
      chk("t6_beats_done", TW'(acc_k), TW'(NB));
      chk("t6_tile_valid", TW'(tile_valid), TW'(1));
      chk("t6_tile_data",  tile_data, gold);
      step(0, 0, 12'h0, 0, 1);

      // Free-running random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         step(($urandom % 100) == 0,
              1'($urandom % 2),
              12'($urandom),
              (m_q.size() == NB-1) ? (($urandom % 8) != 0) : (($urandom % 30) == 0),
              ($urandom % 3) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
